// File: rtl/agc_mem_pkg.sv
// Shared definitions for the AGC erasable-memory path: widths, arbiter states
// and the host operation record.
package agc_mem_pkg;

  localparam int unsigned ERASABLE_AW = 11;
  localparam int unsigned WORD_W      = 15;

  typedef enum logic [1:0] {
    CORE,
    HANDOFF,
    HOST,
    RESTORE
  } arb_state_t;

  typedef struct packed {
    logic                   write;
    logic [ERASABLE_AW-1:0] address;
    logic [WORD_W-1:0]      wdata;
  } host_op_t;

endpackage

// File: rtl/agc_ram_arbiter.sv
// Arbitrates the single erasable-memory port pair between the AGC Core and a
// host loader, with bounded host bursts and a guaranteed Core run window.
module agc_ram_arbiter
  import agc_mem_pkg::*;
#(
  parameter int unsigned MAX_BURST       = 8,
  parameter int unsigned MIN_CORE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ERASABLE_AW-1:0] core_read_address,
  input  logic [ERASABLE_AW-1:0] core_write_address,
  input  logic [WORD_W-1:0]      core_write_data,
  input  logic                   core_write_en,
  input  logic                   core_stall_in,
  output logic                   core_hold,
  input  logic                   host_req,
  input  logic                   host_write,
  input  logic [ERASABLE_AW-1:0] host_address,
  input  logic [WORD_W-1:0]      host_wdata,
  output logic                   host_ready,
  output logic                   host_rvalid,
  output logic [WORD_W-1:0]      host_rdata,
  output logic [ERASABLE_AW-1:0] ram_read_address,
  output logic                   ram_rd_addressstall,
  output logic [ERASABLE_AW-1:0] ram_write_address,
  output logic [WORD_W-1:0]      ram_write_data,
  output logic                   ram_write_en,
  input  logic [WORD_W-1:0]      ram_q
);

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);
  localparam logic [7:0] MinCore  = 8'(MIN_CORE_CYCLES);

  arb_state_t             state_q, state_d;
  logic [7:0]             burst_cnt_q, burst_cnt_d;
  logic [7:0]             cooldown_q, cooldown_d;
  logic [ERASABLE_AW-1:0] saved_rd_addr_q, saved_rd_addr_d;
  logic                   rvalid_q, rvalid_d;
  logic                   accept;
  host_op_t               host_op;

  assign host_op = '{write: host_write, address: host_address, wdata: host_wdata};

  always_comb begin
    state_d             = state_q;
    burst_cnt_d         = burst_cnt_q;
    cooldown_d          = cooldown_q;
    saved_rd_addr_d     = saved_rd_addr_q;
    rvalid_d            = 1'b0;
    accept              = 1'b0;
    core_hold           = 1'b0;
    host_ready          = 1'b0;
    ram_read_address    = core_read_address;
    ram_rd_addressstall = core_stall_in;
    ram_write_address   = core_write_address;
    ram_write_data      = core_write_data;
    ram_write_en        = core_write_en;

    unique case (state_q)
      CORE: begin
        // Track the last address the Core actually presented to the RAM.
        if (!core_stall_in) saved_rd_addr_d = core_read_address;
        if (cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;
        if (host_req && cooldown_q == 8'd0) state_d = HANDOFF;
      end

      HANDOFF: begin
        // Core write port stays connected so an in-flight write completes.
        core_hold           = 1'b1;
        ram_rd_addressstall = 1'b1;
        burst_cnt_d         = 8'd0;
        state_d             = HOST;
      end

      HOST: begin
        core_hold           = 1'b1;
        host_ready          = burst_cnt_q < MaxBurst;
        accept              = host_req && host_ready;
        ram_write_address   = host_op.address;
        ram_write_data      = host_op.wdata;
        ram_write_en        = accept && host_op.write;
        ram_read_address    = host_op.address;
        ram_rd_addressstall = !(accept && !host_op.write);
        rvalid_d            = accept && !host_op.write;
        if (accept) burst_cnt_d = burst_cnt_q + 8'd1;
        if (!accept || burst_cnt_q == MaxBurst - 8'd1) state_d = RESTORE;
      end

      RESTORE: begin
        // Re-present the Core's address so ram_q is valid on its first cycle back.
        core_hold           = 1'b1;
        ram_read_address    = saved_rd_addr_q;
        ram_rd_addressstall = 1'b0;
        ram_write_en        = 1'b0;
        cooldown_d          = MinCore;
        state_d             = CORE;
      end

      default: state_d = CORE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= CORE;
      burst_cnt_q     <= 8'd0;
      cooldown_q      <= 8'd0;
      saved_rd_addr_q <= '0;
      rvalid_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      burst_cnt_q     <= burst_cnt_d;
      cooldown_q      <= cooldown_d;
      saved_rd_addr_q <= saved_rd_addr_d;
      rvalid_q        <= rvalid_d;
    end
  end

  assign host_rvalid = rvalid_q;
  assign host_rdata  = ram_q;

endmodule

// File: doc/agc_ram_arbiter.md
Name: agc_ram_arbiter

Overview:
- Shares the single erasable-memory (agc_ram) port pair, 2048 x 15-bit, between the AGC Core and a host loader/debug port. The host port is intended for the future serial interface that uploads erasable state and reads back results.
- The arbiter sits between Core, agc_ram and the host. It drives the RAM write port, read address and read-address stall, and holds the Core while the host owns memory.
- Host bursts are bounded, and the Core gets a guaranteed minimum run window between bursts.

Parameters:
- MAX_BURST, 8: maximum host operations accepted per grant (1..255).
- MIN_CORE_CYCLES, 4: CORE-state cycles forced after RESTORE before another grant (0..255; 0 = no cooldown).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- core_read_address  in  11  Core RAM read address
- core_write_address  in  11  Core RAM write address
- core_write_data  in  15  Core RAM write data
- core_write_en  in  1  Core RAM write enable
- core_stall_in  in  1  Core's own pipeline stall (normally feeds the RAM addressstall)
- core_hold  out  1  forces Core to stall; asserted whenever the host owns the port
- host_req  in  1  host operation valid
- host_write  in  1  1 = write, 0 = read
- host_address  in  11  host word address
- host_wdata  in  15  host write data
- host_ready  out  1  host operation accepted this cycle when host_req & host_ready
- host_rvalid  out  1  host read data valid
- host_rdata  out  15  host read data; equals ram_q
- ram_read_address  out  11  to agc_ram rdaddress
- ram_rd_addressstall  out  1  to agc_ram rd_addressstall
- ram_write_address  out  11  to agc_ram wraddress
- ram_write_data  out  15  to agc_ram data
- ram_write_en  out  1  to agc_ram wren
- ram_q  in  15  agc_ram q; registered, 1-cycle read latency

Behaviour:
- States: CORE, HANDOFF, HOST, RESTORE. Registers: state, burst_cnt (8b), cooldown (8b), saved_rd_addr (11b), rvalid_q.
- Reset (synchronous, any state): state=CORE, burst_cnt=0, cooldown=0, saved_rd_addr=0, rvalid_q=0.
  - Outputs after reset: core_hold=0, host_ready=0, host_rvalid=0, ram_write_en=0.
  - A reset mid-HOST drops the burst; no host_rvalid is issued for the dropped operation.
- CORE:
  - RAM outputs pass through from Core; ram_rd_addressstall=core_stall_in; core_hold=0; host_ready=0.
  - saved_rd_addr <= core_read_address whenever core_stall_in=0.
  - cooldown decrements to 0.
  - If host_req & cooldown==0 -> HANDOFF.
- HANDOFF (1 cycle):
  - core_hold=1; Core write port still forwarded, so an in-flight Core write completes.
  - ram_rd_addressstall=1; host_ready=0.
  - burst_cnt <= 0; next state HOST.
- HOST:
  - core_hold=1; core_write_en is ignored (ram_write_en only from host).
  - host_ready=1 while burst_cnt<MAX_BURST.
  - Accepted write: ram_write_en=1, ram_write_address=host_address, ram_write_data=host_wdata; memory updated at that edge.
  - Accepted read: ram_read_address=host_address, ram_rd_addressstall=0; host_rvalid=1 in the following cycle with host_rdata=ram_q.
  - With no accepted read: ram_rd_addressstall=1, ram_write_en=0.
  - Each accept increments burst_cnt; one operation per cycle, back-to-back allowed.
  - Exit to RESTORE when host_req=0, or after the accept that makes burst_cnt==MAX_BURST.
- RESTORE (1 cycle):
  - core_hold=1; host_ready=0; ram_read_address=saved_rd_addr; ram_rd_addressstall=0; ram_write_en=0.
  - host_rvalid may be high this cycle for the last HOST read.
  - Next state CORE with cooldown <= MIN_CORE_CYCLES. On the first CORE cycle ram_q holds the Core's pre-handoff read data.
- host_rvalid is rvalid_q, registered from "read accepted"; never asserted in CORE or HANDOFF.
- host_req in HANDOFF, RESTORE, or while cooldown>0 is not accepted. The host must hold the request; no drop or error.
- Read-after-write to the same address in consecutive HOST cycles returns the new data (RAM write-before-read timing is the RAM's property; bench checks with a 1-cycle gap).
- Address width is exact: 11 bits, no wrap logic; all 2048 words reachable.

Decomposition:
- Shared package agc_mem_pkg:
  - ERASABLE_AW=11, WORD_W=15.
  - enum arb_state_t {CORE, HANDOFF, HOST, RESTORE}.
  - typedef host_op_t struct {write, address, wdata}.
- Single module; no sub-module needed. burst_cnt and cooldown are inline counters.

Test Plan:
- Reset then idle, Core reading addr 0x010 -> core_hold=0, ram_read_address=0x010, ram_rd_addressstall follows core_stall_in, host_rvalid=0.
- Host writes 0x040<-15'h1234, 0x041<-15'h7FFF, then reads 0x040 -> host_rvalid one cycle after read accept with host_rdata=15'h1234; core_hold high HANDOFF through RESTORE; exactly 3 host_ready accepts.
- MAX_BURST=8, host_req held with 12 writes -> 8 accepted, RESTORE, 4 CORE cycles with host_ready=0, then HANDOFF and remaining 4 accepted.
- Core write to 0x100 asserted the cycle host_req rises -> write lands (readback 0x100 correct); Core writes during HOST never reach RAM.
- Core read addr 0x2AA when host grabs port, host reads 0x005 -> first CORE cycle after RESTORE: ram_q = contents of 0x2AA.
- Reset asserted mid-burst after a read accept -> next cycle state CORE, core_hold=0, host_rvalid=0.
